// File: rtl/fadd_pipe.sv
// -----------------------------------------------------------------------------
// fadd_pipe -- pipelined IEEE-754 binary32 adder, fixed latency of 3 cycles.
//
// Operands are taken on every rising edge with en=1. The rounded sum appears
// on y three edges later, together with a one-cycle done pulse. The adder never
// stalls, so busy is constantly low. Subnormal inputs and results are flushed
// to signed zero.
//
// Pipeline ranks:
//   r1_* : unpack, flush subnormals, swap so |A| >= |B|, exponent difference,
//          special-value (NaN / Inf) resolution
//   r2_* : align B with guard/round/sticky, add or subtract mantissas
//   r3_* : leading-zero normalisation, carry-out handling, zero detection
//   y    : round, renormalise on rounding carry, overflow/underflow, pack
//
// Build option:
//   FADD_RNE_EN defined   -> round to nearest, ties to even (guard/round/sticky)
//   FADD_RNE_EN undefined -> truncation (round toward zero)
//
// Ports:
//   clk   in  1  : clock, all logic on rising edge
//   rst   in  1  : synchronous reset, active high
//   en    in  1  : operand pair valid this cycle
//   x1    in 32  : operand A, binary32
//   x2    in 32  : operand B, binary32
//   y     out 32 : registered sum, holds its value when done=0
//   done  out 1  : y holds a new result this cycle
//   busy  out 1  : always 0
// -----------------------------------------------------------------------------
module fadd_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        done,
    output logic        busy
);

`ifdef FADD_RNE_EN
    localparam logic RND_EN = 1'b1;
`else
    // Round-up term is tied off; the increment constant-folds away.
    localparam logic RND_EN = 1'b0;
`endif

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Leading-zero count of a 27-bit vector (27 when the vector is zero).
    function automatic logic [4:0] f_lzc27(input logic [26:0] v);
        logic [4:0] cnt;
        logic       found;
        cnt   = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            cnt   = (!found && v[i]) ? 5'(26 - i) : cnt;
            found = found | v[i];
        end
        return cnt;
    endfunction

    assign busy = 1'b0;

    // ---------------------------------------------------------------- stage 1
    logic [30:0] w_a_mag;
    logic [30:0] w_b_mag;
    logic        w_swap;
    logic [30:0] w_big_mag;
    logic [30:0] w_sml_mag;
    logic        w_big_sign;
    logic        w_sml_sign;
    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_spec;
    logic [31:0] w_spec_val;

    // Exponent-0 operands become exact zeros so they sort below everything.
    assign w_a_mag    = (x1[30:23] == 8'd0) ? 31'd0 : x1[30:0];
    assign w_b_mag    = (x2[30:23] == 8'd0) ? 31'd0 : x2[30:0];
    assign w_swap     = (w_b_mag > w_a_mag);
    assign w_big_mag  = w_swap ? w_b_mag : w_a_mag;
    assign w_sml_mag  = w_swap ? w_a_mag : w_b_mag;
    assign w_big_sign = w_swap ? x2[31] : x1[31];
    assign w_sml_sign = w_swap ? x1[31] : x2[31];

    assign w_a_nan = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
    assign w_b_nan = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
    assign w_a_inf = (x1[30:23] == 8'hFF) && (x1[22:0] == 23'd0);
    assign w_b_inf = (x2[30:23] == 8'hFF) && (x2[22:0] == 23'd0);

    // Resolve NaN/Inf operands up front; the arithmetic result is then ignored.
    always_comb begin
        w_spec     = 1'b0;
        w_spec_val = 32'd0;
        if (w_a_nan || w_b_nan) begin
            w_spec     = 1'b1;
            w_spec_val = QNAN;
        end else if (w_a_inf && w_b_inf) begin
            w_spec     = 1'b1;
            w_spec_val = (x1[31] != x2[31]) ? QNAN : {x1[31], 8'hFF, 23'd0};
        end else if (w_a_inf) begin
            w_spec     = 1'b1;
            w_spec_val = {x1[31], 8'hFF, 23'd0};
        end else if (w_b_inf) begin
            w_spec     = 1'b1;
            w_spec_val = {x2[31], 8'hFF, 23'd0};
        end else begin
            w_spec     = 1'b0;
            w_spec_val = 32'd0;
        end
    end

    logic        r1_vld;
    logic        r1_sign_a;
    logic        r1_sign_b;
    logic [7:0]  r1_exp;
    logic [23:0] r1_man_a;
    logic [23:0] r1_man_b;
    logic [7:0]  r1_diff;
    logic        r1_spec;
    logic [31:0] r1_spec_val;

    // Stage-1 register rank: unpacked, swapped operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_vld      <= 1'b0;
            r1_sign_a   <= 1'b0;
            r1_sign_b   <= 1'b0;
            r1_exp      <= 8'd0;
            r1_man_a    <= 24'd0;
            r1_man_b    <= 24'd0;
            r1_diff     <= 8'd0;
            r1_spec     <= 1'b0;
            r1_spec_val <= 32'd0;
        end else begin
            r1_vld      <= en;
            r1_sign_a   <= w_big_sign;
            r1_sign_b   <= w_sml_sign;
            r1_exp      <= w_big_mag[30:23];
            r1_man_a    <= {(w_big_mag[30:23] != 8'd0), w_big_mag[22:0]};
            r1_man_b    <= {(w_sml_mag[30:23] != 8'd0), w_sml_mag[22:0]};
            r1_diff     <= w_big_mag[30:23] - w_sml_mag[30:23];
            r1_spec     <= w_spec;
            r1_spec_val <= w_spec_val;
        end
    end

    // ---------------------------------------------------------------- stage 2
    // Aligned B layout: [26:3] mantissa, [2] guard, [1] round, [0] sticky.
    logic [49:0] w_wide;
    logic [26:0] w_b_aln;
    logic [27:0] w_a_ext;
    logic [27:0] w_b_ext;
    logic [27:0] w_sum;

    // Right-shift B; everything falling off the bottom collapses into sticky.
    always_comb begin
        w_wide = {r1_man_b, 26'd0} >> r1_diff;
        if (r1_diff >= 8'd26) begin
            w_b_aln = {26'd0, |r1_man_b};
        end else begin
            w_b_aln = {w_wide[49:24], |w_wide[23:0]};
        end
    end

    assign w_a_ext = {1'b0, r1_man_a, 3'b000};
    assign w_b_ext = {1'b0, w_b_aln};
    // |A| >= |B|, so the difference is never negative.
    assign w_sum   = (r1_sign_a == r1_sign_b) ? (w_a_ext + w_b_ext) : (w_a_ext - w_b_ext);

    logic        r2_vld;
    logic        r2_sign;
    logic        r2_zsign;
    logic [7:0]  r2_exp;
    logic [27:0] r2_sum;
    logic        r2_spec;
    logic [31:0] r2_spec_val;

    // Stage-2 register rank: raw mantissa sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_vld      <= 1'b0;
            r2_sign     <= 1'b0;
            r2_zsign    <= 1'b0;
            r2_exp      <= 8'd0;
            r2_sum      <= 28'd0;
            r2_spec     <= 1'b0;
            r2_spec_val <= 32'd0;
        end else begin
            r2_vld      <= r1_vld;
            r2_sign     <= r1_sign_a;
            // A zero sum is negative only for (-0)+(-0).
            r2_zsign    <= r1_sign_a & r1_sign_b;
            r2_exp      <= r1_exp;
            r2_sum      <= w_sum;
            r2_spec     <= r1_spec;
            r2_spec_val <= r1_spec_val;
        end
    end

    // ---------------------------------------------------------------- stage 3a
    logic [4:0]        w_lz;
    logic [26:0]       w_nmant;
    logic signed [9:0] w_nexp;
    logic              w_zero;

    assign w_lz   = f_lzc27(r2_sum[26:0]);
    assign w_zero = (r2_sum == 28'd0);

    // Normalise so the hidden bit lands in bit 26.
    always_comb begin
        if (r2_sum[27]) begin
            w_nmant = {r2_sum[27:2], r2_sum[1] | r2_sum[0]};
            w_nexp  = {2'b00, r2_exp} + 10'd1;
        end else begin
            w_nmant = r2_sum[26:0] << w_lz;
            w_nexp  = {2'b00, r2_exp} - {5'd0, w_lz};
        end
    end

    logic              r3_vld;
    logic              r3_sign;
    logic signed [9:0] r3_exp;
    logic [26:0]       r3_mant;
    logic              r3_force;
    logic [31:0]       r3_force_val;

    // Stage-3a register rank: normalised mantissa, or a forced special/zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r3_vld       <= 1'b0;
            r3_sign      <= 1'b0;
            r3_exp       <= 10'sd0;
            r3_mant      <= 27'd0;
            r3_force     <= 1'b0;
            r3_force_val <= 32'd0;
        end else begin
            r3_vld       <= r2_vld;
            r3_sign      <= r2_sign;
            r3_exp       <= w_nexp;
            r3_mant      <= w_nmant;
            r3_force     <= r2_spec | w_zero;
            r3_force_val <= r2_spec ? r2_spec_val : {r2_zsign, 31'd0};
        end
    end

    // ---------------------------------------------------------------- stage 3b
    logic              w_rup;
    logic [24:0]       w_rmant;
    logic [22:0]       w_frac;
    logic signed [9:0] w_rexp;
    logic [31:0]       w_y;

    // Ties go to even: round up on guard when round/sticky or the LSB is set.
    assign w_rup   = RND_EN & r3_mant[2] & (r3_mant[1] | r3_mant[0] | r3_mant[3]);
    assign w_rmant = {1'b0, r3_mant[26:3]} + {24'd0, w_rup};
    assign w_frac  = w_rmant[24] ? w_rmant[23:1] : w_rmant[22:0];
    assign w_rexp  = r3_exp + {9'd0, w_rmant[24]};

    // Range checks are made after rounding so a round-up into the normal range survives.
    always_comb begin
        w_y = 32'd0;
        if (r3_force) begin
            w_y = r3_force_val;
        end else if (w_rexp <= 10'sd0) begin
            w_y = {r3_sign, 31'd0};
        end else if (w_rexp >= 10'sd255) begin
            w_y = {r3_sign, 8'hFF, 23'd0};
        end else begin
            w_y = {r3_sign, w_rexp[7:0], w_frac};
        end
    end

    // Output register: new result with done, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            y    <= 32'd0;
            done <= 1'b0;
        end else begin
            done <= r3_vld;
            if (r3_vld) begin
                y <= w_y;
            end else begin
                y <= y;
            end
        end
    end

endmodule

// File: tb/tb_fadd_pipe.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fadd_pipe. Expected sums are queued when operands are
// driven and compared against the results collected on done.
// -----------------------------------------------------------------------------
module tb_fadd_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic        done;
    logic        busy;

    always #5 clk = ~clk;

    fadd_pipe dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .x1   (x1),
        .x2   (x2),
        .y    (y),
        .done (done),
        .busy (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] val;
        logic [31:0] mask;
        bit          approx;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] obs_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          busy_bad = 1'b0;

    // Collect every result the DUT flags as new.
    always @(negedge clk) begin
        if (done === 1'b1) obs_q.push_back(y);
        if (busy !== 1'b0) busy_bad = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ model
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) d = {f[31], 63'd0};
        else d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Double -> binary32 with round-to-nearest-even; tiny results go to signed zero.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        logic [23:0] man;
        logic [28:0] rem;
        int          fe;
        d = $realtobits(r);
        e = d[62:52];
        if (e == 11'd0) return {d[63], 31'd0};
        fe  = int'(e) - 896;
        man = {1'b0, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && man[0])) man = man + 24'd1;
        if (man[23]) begin
            fe  = fe + 1;
            man = 24'd0;
        end
        if (fe >= 255) return {d[63], 8'hFF, 23'd0};
        if (fe <= 0) return {d[63], 31'd0};
        return {d[63], fe[7:0], man[22:0]};
    endfunction

    function automatic logic [22:0] rand_man();
        logic [22:0] m;
        case ($urandom_range(0, 9))
            0: m = 23'h000000;
            1: m = 23'h000001;
            2: m = 23'h000002;
            3: m = 23'h380000;
            4: m = 23'h400000;
            5: m = 23'h5FFFFF;
            6: m = 23'h7FFFFF;
            default: m = 23'($urandom());
        endcase
        return m;
    endfunction

    // ------------------------------------------------------------ stimulus helpers
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] v, input logic [31:0] m, input bit ap);
        exp_t e;
        @(negedge clk);
        en = 1'b1;
        x1 = a;
        x2 = b;
        e.a = a; e.b = b; e.val = v; e.mask = m; e.approx = ap;
        exp_q.push_back(e);
    endtask

    task automatic idle_and_wait();
        int k;
        @(negedge clk);
        en = 1'b0;
        k  = 0;
        while (obs_q.size() < exp_q.size() && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        repeat (5) @(negedge clk);
        #1;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b1; en = 1'b1; x1 = 32'h3F80_0000; x2 = 32'h3F80_0000;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (y !== 32'd0) begin n_errors++; $display("FAIL reset_y: got %h expected 00000000", y); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != 0) begin
            n_errors++;
            $display("FAIL reset_en_ignored: got %0d results expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_basic();
        logic [3:0]  seen;
        logic [31:0] y_at3;
        logic [31:0] y_at4;
        exp_t        e;
        logic [31:0] o;
        int          idx;
        @(negedge clk);
        en = 1'b1; x1 = 32'h3F80_0000; x2 = 32'h3F80_0000;
        @(posedge clk);
        #1;
        en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            seen[c] = done;
            if (c == 2) y_at3 = y;
            if (c == 3) y_at4 = y;
        end
        n_checks++;
        if (seen !== 4'b0100) begin n_errors++; $display("FAIL latency: done pattern got %b expected 0100", seen); end
        n_checks++;
        if (y_at3 !== 32'h4000_0000) begin n_errors++; $display("FAIL one_plus_one: got %h expected 40000000", y_at3); end
        n_checks++;
        if (y_at4 !== 32'h4000_0000) begin n_errors++; $display("FAIL y_hold: got %h expected 40000000", y_at4); end
        repeat (2) @(negedge clk);
        obs_q.delete();

        send(32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h3F80_0000, 32'h3F00_0000, 32'h3FC0_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'hBFC0_0000, 32'hBFC0_0000, 32'hC040_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h4120_0000, 32'hC0A0_0000, 32'h40A0_0000, 32'hFFFF_FFFF, 1'b0);
        idle_and_wait();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL basic_count: got %0d results expected %0d", obs_q.size(), exp_q.size());
        end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                n_errors++;
                $display("FAIL basic[%0d] %h+%h: got %h expected %h", idx, e.a, e.b, o, e.val);
            end
            idx++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_round_edges();
        exp_t        e;
        logic [31:0] o;
        int          idx;
        send(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 1'b0);
`ifdef FADD_RNE_EN
        send(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 32'hFFFF_FFFF, 1'b0);
        send(32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001, 32'hFFFF_FFFF, 1'b0);
`else
        send(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0001, 32'hFFFF_FFFF, 1'b0);
        send(32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 1'b0);
`endif
        send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h0080_0000, 32'h8080_0001, 32'h8000_0000, 32'hFF80_0000, 1'b0);
        send(32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h3F80_0000, 32'h3280_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h3F80_0001, 32'hBF80_0000, 32'h3400_0000, 32'hFFFF_FFFF, 1'b0);
        idle_and_wait();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL edge_count: got %0d results expected %0d", obs_q.size(), exp_q.size());
        end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                n_errors++;
                $display("FAIL edge[%0d] %h+%h: got %h expected %h", idx, e.a, e.b, o, e.val);
            end
            idx++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_specials();
        exp_t        e;
        logic [31:0] o;
        int          idx;
        send(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h3F80_0000, 32'h7F80_0001, 32'h7FC0_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'hBF80_0000, 32'hFF80_0000, 32'hFF80_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h7F80_0000, 32'h0000_0001, 32'h7F80_0000, 32'hFFFF_FFFF, 1'b0);
        idle_and_wait();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL special_count: got %0d results expected %0d", obs_q.size(), exp_q.size());
        end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                n_errors++;
                $display("FAIL special[%0d] %h+%h: got %h expected %h", idx, e.a, e.b, o, e.val);
            end
            idx++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_streaming();
        exp_t        e;
        logic [31:0] o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] dif;
        logic [7:0]  ea;
        int          eb;
        int          idx;
        bit          ok;
        for (int i = 0; i < 400; i++) begin
            ea = 8'($urandom_range(0, 254));
            a  = {1'($urandom()), ea, rand_man()};
            case ($urandom_range(0, 3))
                0: b = {1'($urandom()), 8'($urandom_range(0, 254)), rand_man()};
                1: begin
                    eb = int'(ea) + int'($urandom_range(0, 6)) - 3;
                    if (eb < 0) eb = 0;
                    if (eb > 254) eb = 254;
                    b = {1'($urandom()), 8'(eb), rand_man()};
                end
                2: b = {1'($urandom()), ea, a[22:10], 10'($urandom())};
                default: b = {~a[31], ea, a[22:6], 6'($urandom())};
            endcase
            send(a, b, r2f(f2r(a) + f2r(b)), 32'hFFFF_FFFF, 1'b1);
        end
        idle_and_wait();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL stream_count: got %0d results expected %0d", obs_q.size(), exp_q.size());
        end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e   = exp_q.pop_front();
            o   = obs_q.pop_front();
            dif = (o > e.val) ? (o - e.val) : (e.val - o);
            ok  = !$isunknown(o) &&
                  (((o[30:23] == 8'd0) && (e.val[30:23] == 8'd0)) ||
                   ((o[31] == e.val[31]) && (dif <= 32'd1)));
            n_checks++;
            if (!ok) begin
                n_errors++;
                $display("FAIL stream[%0d] %h+%h: got %h expected %h (+-1)", idx, e.a, e.b, o, e.val);
            end
            idx++;
        end
        n_checks++;
        if (busy_bad) begin n_errors++; $display("FAIL busy_low: got busy=1 expected 0"); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midstream();
        logic [31:0] y_now;
        int          lat;
        logic [31:0] y_res;
        obs_q.delete(); exp_q.delete();
        @(negedge clk); en = 1'b1; x1 = 32'h3F80_0000; x2 = 32'h3F80_0000;
        @(negedge clk); en = 1'b1; x1 = 32'h4000_0000; x2 = 32'h4000_0000;
        @(negedge clk); en = 1'b1; x1 = 32'h4040_0000; x2 = 32'h3F80_0000;
        @(negedge clk); en = 1'b1; rst = 1'b1; x1 = 32'h4080_0000; x2 = 32'h4080_0000;
        @(negedge clk); en = 1'b0; rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        y_now = y;
        n_checks++;
        if (obs_q.size() != 0) begin
            n_errors++;
            $display("FAIL midreset_done: got %0d results expected 0", obs_q.size());
        end
        n_checks++;
        if (y_now !== 32'd0) begin n_errors++; $display("FAIL midreset_y: got %h expected 00000000", y_now); end

        @(negedge clk); en = 1'b1; x1 = 32'h40A0_0000; x2 = 32'h3F80_0000;
        @(posedge clk);
        #1;
        en  = 1'b0;
        lat = 0;
        y_res = 32'd0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 && lat == 0) begin
                lat   = c;
                y_res = y;
            end
        end
        n_checks++;
        if (lat != 3) begin n_errors++; $display("FAIL midreset_latency: got %0d expected 3", lat); end
        n_checks++;
        if (y_res !== 32'h40C0_0000) begin n_errors++; $display("FAIL midreset_value: got %h expected 40c00000", y_res); end
        repeat (2) @(negedge clk);
        obs_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        x1  = 32'd0;
        x2  = 32'd0;
        test_reset();
        test_basic();
        test_round_edges();
        test_specials();
        test_streaming();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
